// File: rtl/mux_serializer.sv
// ---------------------------------------------------------------------------
// mux_serializer
//
// Parallel-to-serial converter built around an N-to-1 selector. A word is
// captured on load and its channels are presented on f one per clock, with the
// channel order chosen at load time (LSB-first or MSB-first). This takes the
// place of a wide mux tree in designs where the channels are scanned in time.
//
// Parameters
//   N          number of input channels (N >= 2, need not be a power of two)
//   SEL_W      width of the channel index, derived from N (not overridable)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, takes priority over load
//   load       capture w and start a scan (only accepted in IDLE or on the
//              last channel of a scan)
//   w          parallel word, channel i is w[i]
//   msb_first  scan order sampled with load: 0 = w[0] first, 1 = w[N-1] first
//   f          bit of the channel currently selected, 0 when not valid
//   valid      f carries a channel bit this cycle
//   sel        index of the channel currently on f
//   done       high in the cycle the final channel of a scan is on f
//   busy       high while a scan is in progress (same as valid)
// ---------------------------------------------------------------------------
module mux_serializer #(
    parameter int N = 16,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N-1:0]     w,
    input  logic             msb_first,
    output logic             f,
    output logic             valid,
    output logic [SEL_W-1:0] sel,
    output logic             done,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [SEL_W-1:0] TOP_IDX = SEL_W'(N - 1);

    state_t           state;
    logic [N-1:0]     word_q;
    logic [SEL_W-1:0] idx;
    logic             dir_q;

    logic [SEL_W-1:0] last_idx;
    logic             at_last;
    logic             in_shift;

    // The scan ends at the top channel when counting up and at channel 0 when
    // counting down; stopping here keeps idx inside 0..N-1 for any N.
    assign last_idx = dir_q ? '0 : TOP_IDX;
    assign at_last  = (idx == last_idx);
    assign in_shift = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            word_q <= '0;
            idx    <= '0;
            dir_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        word_q <= w;
                        dir_q  <= msb_first;
                        idx    <= msb_first ? TOP_IDX : '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (at_last) begin
                        // A load on the final channel chains straight into the
                        // next scan so there is no idle cycle between words.
                        if (load) begin
                            word_q <= w;
                            dir_q  <= msb_first;
                            idx    <= msb_first ? TOP_IDX : '0;
                            state  <= SHIFT;
                        end else begin
                            idx   <= '0;
                            state <= IDLE;
                        end
                    end else if (dir_q) begin
                        idx <= idx - SEL_W'(1);
                    end else begin
                        idx <= idx + SEL_W'(1);
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // All outputs decode directly from registered state, so they are glitch
    // free relative to the clock and settle with the state update.
    assign valid = in_shift;
    assign busy  = in_shift;
    assign sel   = idx;
    assign f     = in_shift & word_q[idx];
    assign done  = in_shift & at_last;

endmodule

// File: tb/tb_mux_serializer.sv
// ---------------------------------------------------------------------------
// tb_mux_serializer
//
// Directed self-checking bench for mux_serializer. One instance uses the
// default 16 channels, a second uses 5 channels to cover a non-power-of-two
// width. Inputs change on the falling edge, outputs are sampled on the falling
// edge before new inputs are applied.
// ---------------------------------------------------------------------------
module tb_mux_serializer;

    logic       clk;
    logic       rst;

    logic        load16;
    logic [15:0] w16;
    logic        msb16;
    logic        f16;
    logic        valid16;
    logic [3:0]  sel16;
    logic        done16;
    logic        busy16;

    logic        load5;
    logic [4:0]  w5;
    logic        msb5;
    logic        f5;
    logic        valid5;
    logic [2:0]  sel5;
    logic        done5;
    logic        busy5;

    int total;
    int bad;

    // Expected channel sequences, written out by hand from the test word
    // 16'b1010_1100_1111_0001.
    int lsb_seq [16] = '{1,0,0,0,1,1,1,1,0,0,1,1,0,1,0,1};
    int msb_seq [16] = '{1,0,1,0,1,1,0,0,1,1,1,1,0,0,0,1};
    int n5_seq  [5]  = '{0,1,1,0,1};

    mux_serializer #(.N(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .load      (load16),
        .w         (w16),
        .msb_first (msb16),
        .f         (f16),
        .valid     (valid16),
        .sel       (sel16),
        .done      (done16),
        .busy      (busy16)
    );

    mux_serializer #(.N(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .load      (load5),
        .w         (w5),
        .msb_first (msb5),
        .f         (f5),
        .valid     (valid5),
        .sel       (sel5),
        .done      (done5),
        .busy      (busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vectors are packed as {valid, busy, done, f, sel}.
    task automatic test_reset();
        logic [7:0] got16, exp16;
        logic [6:0] got5, exp5;
        @(negedge clk);
        rst    = 1'b1;
        load16 = 1'b1;
        w16    = 16'hFFFF;
        msb16  = 1'b1;
        load5  = 1'b1;
        w5     = 5'h1F;
        msb5   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            got16 = {valid16, busy16, done16, f16, sel16};
            exp16 = 8'h00;
            total++;
            if (got16 !== exp16) begin
                bad++;
                $display("[TB] FAIL reset16 cyc=%0d got=%b want=%b", c, got16, exp16);
            end
            got5 = {valid5, busy5, done5, f5, sel5};
            exp5 = 7'h00;
            total++;
            if (got5 !== exp5) begin
                bad++;
                $display("[TB] FAIL reset5 cyc=%0d got=%b want=%b", c, got5, exp5);
            end
        end
        rst    = 1'b0;
        load16 = 1'b0;
        load5  = 1'b0;
        msb16  = 1'b0;
        msb5   = 1'b0;
    endtask

    task automatic test_scan(input logic msb);
        logic [7:0] got, exp;
        logic [3:0] s;
        @(negedge clk);
        load16 = 1'b1;
        w16    = 16'b1010_1100_1111_0001;
        msb16  = msb;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load16 = 1'b0;
            w16    = 16'h0000;
            s   = msb ? 4'(15 - i) : 4'(i);
            exp = {1'b1, 1'b1, (i == 15), (msb ? msb_seq[i][0] : lsb_seq[i][0]), s};
            got = {valid16, busy16, done16, f16, sel16};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL scan msb=%0b step=%0d got=%b want=%b", msb, i, got, exp);
            end
        end
        @(negedge clk);
        got = {valid16, busy16, done16, f16, sel16};
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("[TB] FAIL scan_idle msb=%0b got=%b want=%b", msb, got, 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, exp;
        int dones;
        dones = 0;
        @(negedge clk);
        load16 = 1'b1;
        w16    = 16'hFFFF;
        msb16  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            exp = {1'b1, 1'b1, (i == 15 || i == 31), (i < 16), 4'(i % 16)};
            got = {valid16, busy16, done16, f16, sel16};
            if (done16 === 1'b1) dones++;
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL b2b step=%0d got=%b want=%b", i, got, exp);
            end
            if (i == 15) w16 = 16'h0000;
            if (i == 31) load16 = 1'b0;
        end
        total++;
        if (dones !== 2) begin
            bad++;
            $display("[TB] FAIL b2b_done_count got=%0d want=2", dones);
        end
        @(negedge clk);
        got = {valid16, busy16, done16, f16, sel16};
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("[TB] FAIL b2b_idle got=%b want=%b", got, 8'h00);
        end
    endtask

    task automatic test_ignored_load();
        logic [7:0] got, exp;
        @(negedge clk);
        load16 = 1'b1;
        w16    = 16'b1010_1100_1111_0001;
        msb16  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load16 = 1'b0;
            exp = {1'b1, 1'b1, (i == 15), lsb_seq[i][0], 4'(i)};
            got = {valid16, busy16, done16, f16, sel16};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL ign_load step=%0d got=%b want=%b", i, got, exp);
            end
            if (i == 5) begin
                load16 = 1'b1;
                w16    = 16'h0000;
                msb16  = 1'b1;
            end
        end
        msb16 = 1'b0;
        @(negedge clk);
        got = {valid16, busy16, done16, f16, sel16};
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("[TB] FAIL ign_load_idle got=%b want=%b", got, 8'h00);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] got, exp;
        @(negedge clk);
        load16 = 1'b1;
        w16    = 16'b1010_1100_1111_0001;
        msb16  = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            load16 = 1'b0;
            exp = {1'b1, 1'b1, 1'b0, lsb_seq[i][0], 4'(i)};
            got = {valid16, busy16, done16, f16, sel16};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL rst_mid step=%0d got=%b want=%b", i, got, exp);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            got = {valid16, busy16, done16, f16, sel16};
            total++;
            if (got !== 8'h00) begin
                bad++;
                $display("[TB] FAIL rst_mid_after cyc=%0d got=%b want=%b", c, got, 8'h00);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_n5();
        logic [6:0] got, exp;
        @(negedge clk);
        load5 = 1'b1;
        w5    = 5'b10110;
        msb5  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            load5 = 1'b0;
            w5    = 5'b00000;
            exp = {1'b1, 1'b1, (i == 4), n5_seq[i][0], 3'(i)};
            got = {valid5, busy5, done5, f5, sel5};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL n5 step=%0d got=%b want=%b", i, got, exp);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got = {valid5, busy5, done5, f5, sel5};
            total++;
            if (got !== 7'h00) begin
                bad++;
                $display("[TB] FAIL n5_idle cyc=%0d got=%b want=%b", c, got, 7'h00);
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        load16 = 1'b0;
        w16    = '0;
        msb16  = 1'b0;
        load5  = 1'b0;
        w5     = '0;
        msb5   = 1'b0;

        $display("[TB] starting mux_serializer bench");
        test_reset();
        test_scan(1'b0);
        test_scan(1'b1);
        test_back_to_back();
        test_ignored_load();
        test_reset_mid_scan();
        test_n5();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
